// File: rtl/bpu_btb_ras_pkg.sv
// bpu_btb_ras_pkg: shared widths, opcode constants and helpers for the branch predictor.
package bpu_btb_ras_pkg;
    localparam int pc_size = 32;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    // Widest tag any legal TABLE_SIZE (>=16) can need; narrower tags are zero-extended.
    localparam int MAX_TAG_BITS = pc_size - 6;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [MAX_TAG_BITS-1:0] tag;
        logic [pc_size-1:0]      target;
    } btb_entry_t;
endpackage

// File: rtl/bpu_btb_ras_ras_stack.sv
// ras_stack: circular return-address stack with overwrite-oldest overflow and pointer restore.
module ras_stack
    import bpu_btb_ras_pkg::*;
#(
    parameter int RAS_DEPTH = 8,
    parameter int PTR_BITS  = log2(RAS_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [pc_size-1:0]  push_addr,
    input  logic                restore,
    input  logic [PTR_BITS-1:0] restore_ptr,
    output logic [pc_size-1:0]  top,
    output logic [PTR_BITS-1:0] ptr,
    output logic                empty
);
    localparam int IDX_BITS = PTR_BITS - 1;
    localparam logic [PTR_BITS-1:0] DEPTH = PTR_BITS'(RAS_DEPTH);

    logic [pc_size-1:0]  mem [RAS_DEPTH];
    logic [PTR_BITS-1:0] cnt;
    logic [PTR_BITS-1:0] ptr_m1;

    assign ptr_m1 = ptr - 1'b1;
    assign top    = mem[ptr_m1[IDX_BITS-1:0]];
    assign empty  = cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (restore) begin
            // The snapshot carries only the pointer; occupancy is taken as its clipped value.
            ptr <= restore_ptr;
            cnt <= restore_ptr > DEPTH ? DEPTH : restore_ptr;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt == DEPTH ? cnt : cnt + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr_m1;
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) if (push && !restore) mem[ptr[IDX_BITS-1:0]] <= push_addr;
endmodule

// File: rtl/bpu_btb_ras.sv
// bpu_btb_ras: direct-mapped BTB with saturating counters plus a return-address stack.
module bpu_btb_ras
    import bpu_btb_ras_pkg::*;
#(
    parameter int TABLE_SIZE = 512,
    parameter int CNT_BITS   = 2,
    parameter int RAS_DEPTH  = 8,
    parameter int TAG_BITS   = pc_size - log2(TABLE_SIZE) - 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pc_en,
    input  logic [pc_size-1:0]             pc,
    input  logic                           f_call,
    input  logic                           f_ret,
    output logic                           pred_taken,
    output logic [pc_size-1:0]             pred_target,
    output logic [log2(RAS_DEPTH):0]       pred_ras_ptr,
    input  logic                           res_valid,
    input  logic [pc_size-1:0]             res_pc,
    input  logic                           res_taken,
    input  logic [pc_size-1:0]             res_target,
    input  logic                           res_pred_taken,
    input  logic [pc_size-1:0]             res_pred_target,
    input  logic                           res_is_ret,
    input  logic [log2(RAS_DEPTH):0]       res_ras_ptr,
    output logic                           flush,
    output logic [pc_size-1:0]             redirect_pc
);
    localparam int IDX_BITS = log2(TABLE_SIZE);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - 1'b1;

    logic                valid_q  [TABLE_SIZE];
    logic [TAG_BITS-1:0] tag_q    [TABLE_SIZE];
    logic [pc_size-1:0]  target_q [TABLE_SIZE];
    logic [CNT_BITS-1:0] cnt_q    [TABLE_SIZE];

    logic [IDX_BITS-1:0] f_idx, r_idx;
    logic [TAG_BITS-1:0] f_tag, r_tag;
    btb_entry_t          f_ent, r_ent;
    logic                f_hit, r_hit, ret_hit, btb_take, mispredict, upd;
    logic [CNT_BITS-1:0] r_cnt;
    logic [pc_size-1:0]  ras_top;
    logic                ras_empty;

    assign f_idx = pc[IDX_BITS+1:2];
    assign f_tag = pc[pc_size-1:IDX_BITS+2];
    assign r_idx = res_pc[IDX_BITS+1:2];
    assign r_tag = res_pc[pc_size-1:IDX_BITS+2];

    always_comb begin
        f_ent = '{valid: valid_q[f_idx], tag: MAX_TAG_BITS'(tag_q[f_idx]), target: target_q[f_idx]};
        r_ent = '{valid: valid_q[r_idx], tag: MAX_TAG_BITS'(tag_q[r_idx]), target: target_q[r_idx]};
    end

    assign f_hit    = f_ent.valid && f_ent.tag == MAX_TAG_BITS'(f_tag);
    assign r_hit    = r_ent.valid && r_ent.tag == MAX_TAG_BITS'(r_tag);
    assign ret_hit  = f_ret && !ras_empty;
    assign btb_take = f_hit && (cnt_q[f_idx][CNT_BITS-1] || f_call);

    assign pred_taken  = !rst && (ret_hit || btb_take);
    assign pred_target = ret_hit ? ras_top : btb_take ? f_ent.target : pc + pc_size'(4);

    assign mispredict  = res_valid && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target));
    assign flush       = !rst && mispredict;
    assign redirect_pc = res_taken ? res_target : res_pc + pc_size'(4);

    assign upd   = res_valid && !res_is_ret;
    assign r_cnt = cnt_q[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
        end else if (upd) begin
            if (r_hit)
                cnt_q[r_idx] <= res_taken ? (r_cnt == CNT_MAX ? r_cnt : r_cnt + 1'b1)
                                          : (r_cnt == '0 ? r_cnt : r_cnt - 1'b1);
            else if (res_taken) begin
                valid_q[r_idx] <= 1'b1;
                cnt_q[r_idx]   <= CNT_WT;
            end
        end
    end

    // Tag and target need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (upd && res_taken && (!r_hit || r_ent.target != res_target)) begin
            tag_q[r_idx]    <= r_tag;
            target_q[r_idx] <= res_target;
        end
    end

    ras_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk        (clk),
        .rst        (rst),
        .push       (pc_en && f_call && !flush),
        .pop        (pc_en && f_ret && !flush),
        .push_addr  (pc + pc_size'(4)),
        .restore    (flush),
        .restore_ptr(res_ras_ptr),
        .top        (ras_top),
        .ptr        (pred_ras_ptr),
        .empty      (ras_empty)
    );
endmodule

// File: tb/tb_bpu_btb_ras.sv
// tb_bpu_btb_ras: directed scoreboard bench for the BTB/RAS predictor.
module tb_bpu_btb_ras;
    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en, f_call, f_ret;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_ras_ptr;
    logic        res_valid, res_taken, res_pred_taken, res_is_ret;
    logic [31:0] res_pc, res_target, res_pred_target;
    logic [3:0]  res_ras_ptr;
    logic        flush;
    logic [31:0] redirect_pc;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   total  = 0;
    int   passed = 0;

    bpu_btb_ras dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .pc(pc), .f_call(f_call), .f_ret(f_ret),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ras_ptr(pred_ras_ptr),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .res_is_ret(res_is_ret), .res_ras_ptr(res_ras_ptr),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_en = 0; f_call = 0; f_ret = 0; pc = 32'h3000;
        res_valid = 0; res_pc = 0; res_taken = 0; res_target = 0;
        res_pred_taken = 0; res_pred_target = 0; res_is_ret = 0; res_ras_ptr = 0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic en, input logic call, input logic ret);
        pc = a; pc_en = en; f_call = call; f_ret = ret;
    endtask

    task automatic resolve(input logic [31:0] a, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt, input logic [3:0] rp);
        res_valid = 1; res_pc = a; res_taken = tk; res_target = tgt;
        res_pred_taken = ptk; res_pred_target = ptgt; res_is_ret = 0; res_ras_ptr = rp;
    endtask

    task automatic ex(input string n, input logic [31:0] v);
        sb_q.push_back('{name: n, value: v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard: observed %h with no expectation queued", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.value) passed++;
        else $error("FAIL %s: observed %h expected %h", e.name, obs, e.value);
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        ex("reset_flush", 0); ex("reset_pred_taken", 0); ex("reset_ras_ptr", 0);
        #1;
        chk(flush); chk(pred_taken); chk(pred_ras_ptr);
        rst = 0;
        tick();

        // cold miss with a same-cycle fetch of the index being written
        fetch(32'h100, 0, 0, 0);
        resolve(32'h100, 1, 32'h200, 0, 32'h104, 0);
        ex("cold_flush", 1); ex("cold_redirect", 32'h200); ex("cold_read_prewrite", 0);
        #1;
        chk(flush); chk(redirect_pc); chk(pred_taken);
        tick();
        idle(); fetch(32'h100, 0, 0, 0);
        ex("alloc_taken", 1); ex("alloc_target", 32'h200);
        #1;
        chk(pred_taken); chk(pred_target);

        // saturation: counter 2 -> 3 and stays there
        for (int i = 0; i < 4; i++) begin
            resolve(32'h100, 1, 32'h200, 1, 32'h200, 0);
            ex("sat_no_flush", 0);
            #1;
            chk(flush);
            tick();
        end
        resolve(32'h100, 0, 32'h200, 1, 32'h200, 0);
        ex("nt_flush", 1); ex("nt_redirect", 32'h104);
        #1;
        chk(flush); chk(redirect_pc);
        tick();
        idle(); fetch(32'h100, 0, 0, 0);
        ex("cnt2_still_taken", 1);
        #1;
        chk(pred_taken);
        resolve(32'h100, 0, 32'h200, 1, 32'h200, 0);
        tick();
        idle(); fetch(32'h100, 0, 0, 0);
        ex("cnt1_not_taken", 0); ex("cnt1_target", 32'h104);
        #1;
        chk(pred_taken); chk(pred_target);
        resolve(32'h100, 1, 32'h200, 0, 32'h104, 0);
        tick();

        // aliasing: 0x900 shares the index of 0x100 with a different tag
        idle(); fetch(32'h900, 0, 0, 0);
        ex("alias_taken", 0); ex("alias_target", 32'h904);
        #1;
        chk(pred_taken); chk(pred_target);

        // simple call / return
        fetch(32'h400, 1, 1, 0);
        ex("call_ptr_before", 0);
        #1;
        chk(pred_ras_ptr);
        tick();
        fetch(32'h500, 0, 0, 1);
        ex("ret_taken", 1); ex("ret_target", 32'h404); ex("ret_ptr", 1);
        #1;
        chk(pred_taken); chk(pred_target); chk(pred_ras_ptr);
        pc_en = 1;
        tick();
        ex("pop_ptr", 0); ex("empty_ret_taken", 0); ex("empty_ret_target", 32'h504);
        #1;
        chk(pred_ras_ptr); chk(pred_taken); chk(pred_target);

        // RAS_DEPTH+1 nested calls, then returns
        for (int i = 0; i < 9; i++) begin
            fetch(32'h1000 + 32'(i) * 32'h10, 1, 1, 0);
            tick();
        end
        fetch(32'h3000, 0, 0, 1);
        ex("overflow_ptr", 9);
        #1;
        chk(pred_ras_ptr);
        for (int k = 0; k < 8; k++) begin
            fetch(32'h3000, 1, 0, 1);
            ex("nested_ret", 32'h1004 + 32'(8 - k) * 32'h10);
            #1;
            chk(pred_target);
            tick();
        end
        fetch(32'h100, 1, 0, 1);
        ex("extra_ret_taken", 1); ex("extra_ret_btb", 32'h200);
        #1;
        chk(pred_taken); chk(pred_target);
        tick();

        // flush suppresses a same-cycle push and restores the pointer
        idle();
        fetch(32'h600, 1, 1, 0);
        resolve(32'h700, 0, 32'h0, 1, 32'h800, 2);
        ex("fp_flush", 1); ex("fp_redirect", 32'h704);
        #1;
        chk(flush); chk(redirect_pc);
        tick();
        idle(); fetch(32'h3000, 0, 0, 1);
        ex("fp_ptr", 2); ex("fp_top_intact", 32'h1014);
        #1;
        chk(pred_ras_ptr); chk(pred_target);
        fetch(32'h700, 0, 0, 0);
        ex("nt_miss_no_alloc", 0);
        #1;
        chk(pred_taken);

        // asynchronous reset pulse between clock edges
        fetch(32'h100, 0, 0, 0);
        resolve(32'h100, 1, 32'h300, 1, 32'h200, 0);
        ex("pre_rst_flush", 1); ex("pre_rst_taken", 1);
        #1;
        chk(flush); chk(pred_taken);
        rst = 1;
        ex("async_flush", 0); ex("async_taken", 0); ex("async_ptr", 0);
        #1;
        chk(flush); chk(pred_taken); chk(pred_ras_ptr);
        idle();
        #1;
        rst = 0;
        tick();
        fetch(32'h100, 0, 0, 0);
        ex("post_rst_miss", 0); ex("post_rst_target", 32'h104);
        #1;
        chk(pred_taken); chk(pred_target);
        fetch(32'h3000, 0, 0, 1);
        ex("post_rst_ras_empty", 32'h3004);
        #1;
        chk(pred_target);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
